regfile_bank: RTL and testbench
===============================

REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 Parameter XLEN, default 32, register data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, 2..64; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports, 1..3.
REQ-004 Parameter BYPASS, default 1, 1 = same-cycle write data forwarded to reads.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 rs_addr  input  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
REQ-008 rs_data  output  NRD*XLEN  registered read data; port i uses bits [i*XLEN +: XLEN].
REQ-009 rs_busy  output  NRD  registered pending-write flag per read port.
REQ-010 wr_en  input  1  write strobe.
REQ-011 rd  input  AW  write address.
REQ-012 data_in  input  XLEN  write data.
REQ-013 busy_set  input  1  marks register busy_rd as having a pending producer.
REQ-014 busy_rd  input  AW  register to mark pending.
REQ-015 ready  output  1  high when the bank accepts reads and writes.

Function
REQ-016 The controller SHALL have two states: CLEAR (zero sweep) and RUN.
REQ-017 In CLEAR, a sweep counter cnt SHALL write 0 to register cnt each cycle and increment, starting at 0.
REQ-018 When cnt == NREGS-1 is written, the next state SHALL be RUN; the sweep lasts exactly NREGS cycles.
REQ-019 ready SHALL be 0 in CLEAR and 1 in RUN, registered with the state.
REQ-020 In CLEAR, wr_en and busy_set SHALL be ignored, and rs_data and rs_busy SHALL be held at 0.
REQ-021 In RUN, when wr_en=1 and rd!=0, register rd SHALL take data_in at the edge; when rd==0, the write SHALL be discarded.
REQ-022 Register 0 SHALL always read 0 and never be busy.
REQ-023 Reads SHALL have 1-cycle latency: rs_data port i SHALL load the value of register rs_addr[i] at the edge after the address is presented.
REQ-024 With BYPASS=1, wr_en=1, rd==rs_addr[i] and rd!=0 in the same cycle, port i SHALL load data_in.
REQ-025 With BYPASS=0, port i SHALL instead load the old register value.
REQ-026 Scoreboard, one bit per register:
- wr_en with rd!=0 clears bit rd.
- busy_set with busy_rd!=0 sets bit busy_rd.
- A set and a clear of the same register in the same cycle leave the bit set.
REQ-027 rs_busy[i] SHALL load the scoreboard bit for rs_addr[i] after that cycle's set/clear update is applied, consistent with REQ-024.
REQ-028 All read ports SHALL operate independently, including identical addresses on several ports.

Reset
REQ-029 When rst=1 at an edge:
- state SHALL go to CLEAR and cnt to 0.
- ready, rs_data and rs_busy SHALL go to 0.
- All scoreboard bits SHALL clear.
REQ-030 rst asserted mid-sweep SHALL restart the sweep from register 0.
REQ-031 rst held high SHALL keep the block in CLEAR with cnt=0, and the sweep SHALL begin on the first edge with rst=0.
REQ-032 No register content SHALL be assumed valid before a complete sweep.

Verification
REQ-033 Reset release, NREGS=32 -> ready=0 for 32 cycles then 1; reads of x1..x31 return 0.
REQ-034 RUN, write x5=0xDEADBEEF; next cycle rs_addr0=5 -> rs_data0=0xDEADBEEF one cycle later.
REQ-035 Write x0=0xFFFFFFFF and read x0 on both ports -> both ports return 0 and rs_busy=0.
REQ-036 BYPASS=1, same-cycle write x7=0x12345678 and read x7 -> rs_data=0x12345678.
- Repeat with BYPASS=0 -> old value of x7.
REQ-037 busy_set x9, then read x9 -> rs_busy=1.
- Same cycle busy_set x9 and write x9 -> bit stays 1.
- Later write x9 alone -> rs_busy=0.
REQ-038 Assert rst at sweep cycle 10 -> sweep restarts at 0, ready rises exactly 32 cycles after rst deasserts, and the scoreboard is empty.

Source files
------------

// File: rtl/regfile_bank.sv
// Multi-port register bank with a zero-sweep on reset, optional write-to-read
// bypass and a per-register pending-write scoreboard.
//
// state | meaning
// CLEAR | sweep writes zero to one register per cycle; writes, busy marks ignored
// RUN   | normal operation; reads registered, writes and busy marks accepted
module regfile_bank #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NRD*$clog2(NREGS)-1:0]      rs_addr_i,
  output logic [NRD*XLEN-1:0]               rs_data_o,
  output logic [NRD-1:0]                    rs_busy_o,
  input  logic                              wr_en_i,
  input  logic [$clog2(NREGS)-1:0]          rd_i,
  input  logic [XLEN-1:0]                   data_in_i,
  input  logic                              busy_set_i,
  input  logic [$clog2(NREGS)-1:0]          busy_rd_i,
  output logic                              ready_o
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                ready_q;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    sb_q, sb_d;
  logic [NRD*XLEN-1:0] rs_data_q, rs_data_d;
  logic [NRD-1:0]      rs_busy_q, rs_busy_d;
  logic                wr_act, set_act;

  // Writes and busy marks only take effect in RUN and never target x0.
  assign wr_act  = (state_q == RUN) && wr_en_i    && (rd_i      != '0);
  assign set_act = (state_q == RUN) && busy_set_i && (busy_rd_i != '0);

  // Next-state logic: sweep counter walks every register once, then RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(NREGS - 1)) state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
      end
      default: state_d = CLEAR;
    endcase
  end

  // State register; ready tracks the state it is registered with.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == RUN);
    end
  end

  // Scoreboard update: a set wins over a clear of the same register.
  always_comb begin
    sb_d = sb_q;
    if (wr_act)  sb_d[rd_i]      = 1'b0;
    if (set_act) sb_d[busy_rd_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Read ports: registered data with optional bypass, busy from updated scoreboard.
  always_comb begin
    logic [AW-1:0] a;
    a         = '0;
    rs_data_d = '0;
    rs_busy_d = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < NRD; i++) begin
        a = rs_addr_i[i*AW +: AW];
        if (a != '0) begin
          rs_data_d[i*XLEN +: XLEN] = regs_q[a];
          if ((BYPASS != 0) && wr_act && (rd_i == a)) rs_data_d[i*XLEN +: XLEN] = data_in_i;
          rs_busy_d[i] = sb_d[a];
        end
      end
    end
  end

  // Read output and scoreboard registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q      <= '0;
      rs_data_q <= '0;
      rs_busy_q <= '0;
    end else begin
      sb_q      <= sb_d;
      rs_data_q <= rs_data_d;
      rs_busy_q <= rs_busy_d;
    end
  end

  // Register array: zero sweep in CLEAR, accepted writes in RUN; contents not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == CLEAR) regs_q[cnt_q] <= '0;
      else if (wr_act)      regs_q[rd_i]  <= data_in_i;
    end
  end

  assign rs_data_o = rs_data_q;
  assign rs_busy_o = rs_busy_q;
  assign ready_o   = ready_q;

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: one bypassing and one non-bypassing
// instance share the same stimulus.
module tb_regfile_bank;

  logic        clk;
  logic        rst;
  logic [9:0]  rs_addr;
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] data_in;
  logic        busy_set;
  logic [4:0]  busy_rd;

  logic [63:0] data_b, data_nb;
  logic [1:0]  busy_b, busy_nb;
  logic        ready_b, ready_nb;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  regfile_bank #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_byp (
    .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(data_b),
    .rs_busy_o(busy_b), .wr_en_i(wr_en), .rd_i(rd), .data_in_i(data_in),
    .busy_set_i(busy_set), .busy_rd_i(busy_rd), .ready_o(ready_b)
  );

  regfile_bank #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_nobyp (
    .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(data_nb),
    .rs_busy_o(busy_nb), .wr_en_i(wr_en), .rd_i(rd), .data_in_i(data_in),
    .busy_set_i(busy_set), .busy_rd_i(busy_rd), .ready_o(ready_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; rd = '0; data_in = '0; busy_set = 1'b0; busy_rd = '0;
  endtask

  initial begin
    rst = 1'b1; rs_addr = '0; idle();
    tick(); tick();
    check("rst_ready_b",  ready_b,  1'b0);
    check("rst_ready_nb", ready_nb, 1'b0);
    check("rst_data",     data_b,   64'h0);
    check("rst_busy",     busy_b,   2'b00);

    // Sweep with writes and busy marks held active; they must be ignored.
    rst = 1'b0;
    rs_addr = {5'd3, 5'd2};
    wr_en = 1'b1; rd = 5'd2; data_in = 32'h55555555;
    busy_set = 1'b1; busy_rd = 5'd3;
    n = 0;
    while (ready_b !== 1'b1 && n < 40) begin
      tick();
      n++;
      check("clear_data", data_b, 64'h0);
      check("clear_busy", busy_b, 2'b00);
    end
    check("sweep_len",   n,        32);
    check("sweep_rdy_nb", ready_nb, 1'b1);
    idle();
    tick();
    check("clear_ignored_wr",   data_b[31:0], 32'h0);
    check("clear_ignored_busy", busy_b,       2'b00);

    for (int i = 1; i < 32; i++) begin
      rs_addr = {5'(i), 5'(i)};
      tick();
      check("swept_zero", data_b,  64'h0);
      check("swept_nb",   data_nb, 64'h0);
    end

    // Plain write then read one cycle later.
    rs_addr = '0;
    wr_en = 1'b1; rd = 5'd5; data_in = 32'hDEADBEEF;
    tick();
    idle(); rs_addr = {5'd0, 5'd5};
    tick();
    check("rd_x5_p0",    data_b[31:0],  32'hDEADBEEF);
    check("rd_x5_nb_p0", data_nb[31:0], 32'hDEADBEEF);
    check("rd_x0_p1",    data_b[63:32], 32'h0);

    // Writes to x0 are discarded on both ports.
    wr_en = 1'b1; rd = 5'd0; data_in = 32'hFFFFFFFF; rs_addr = {5'd0, 5'd0};
    tick();
    check("x0_bypass", data_b, 64'h0);
    check("x0_busy",   busy_b, 2'b00);
    idle();
    tick();
    check("x0_after", data_b, 64'h0);

    // Bypass versus old value on same-cycle write and read.
    wr_en = 1'b1; rd = 5'd7; data_in = 32'h11111111; rs_addr = '0;
    tick();
    data_in = 32'h12345678; rs_addr = {5'd7, 5'd7};
    tick();
    check("byp_x7",   data_b,  {32'h12345678, 32'h12345678});
    check("nobyp_x7", data_nb, {32'h11111111, 32'h11111111});
    idle();
    tick();
    check("x7_settled_b",  data_b,  {32'h12345678, 32'h12345678});
    check("x7_settled_nb", data_nb, {32'h12345678, 32'h12345678});

    // Scoreboard.
    busy_set = 1'b1; busy_rd = 5'd9; rs_addr = {5'd10, 5'd9};
    tick();
    check("busy_same_cycle", busy_b, 2'b01);
    idle();
    tick();
    check("busy_x9",    busy_b,  2'b01);
    check("busy_x9_nb", busy_nb, 2'b01);
    busy_set = 1'b1; busy_rd = 5'd9; wr_en = 1'b1; rd = 5'd9; data_in = 32'h00000099;
    rs_addr = {5'd9, 5'd9};
    tick();
    check("set_clr_same", busy_b, 2'b11);
    idle();
    tick();
    check("set_wins",    busy_b,        2'b11);
    check("x9_data",     data_b[31:0],  32'h00000099);
    wr_en = 1'b1; rd = 5'd9; data_in = 32'h00000AAA;
    tick();
    check("clr_busy",    busy_b,        2'b00);
    check("clr_byp",     data_b[31:0],  32'h00000AAA);
    check("clr_nobyp",   data_nb[31:0], 32'h00000099);
    idle();
    busy_set = 1'b1; busy_rd = 5'd0; rs_addr = {5'd0, 5'd0};
    tick();
    check("x0_never_busy", busy_b, 2'b00);
    idle();

    // Leave state behind, then reset mid-sweep.
    busy_set = 1'b1; busy_rd = 5'd12; wr_en = 1'b1; rd = 5'd13; data_in = 32'h0000ABCD;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_sweep_ready", ready_b, 1'b0);
    rst = 1'b1;
    tick();
    check("rst2_ready", ready_b, 1'b0);
    check("rst2_data",  data_b,  64'h0);
    tick(); tick();
    check("rst_held", ready_b, 1'b0);
    rst = 1'b0;
    rs_addr = {5'd12, 5'd13};
    n = 0;
    while (ready_b !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("resweep_len", n, 32);
    tick();
    check("resweep_x13", data_b[31:0], 32'h0);
    check("sb_cleared",  busy_b,       2'b00);
    check("sb_cleared_nb", busy_nb,    2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
